// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared FSM state type and digit-count helper for bin2bcd
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int digits(input int width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/bin2bcd_add3.sv
// rtl/bin2bcd_add3.sv - double-dabble per-digit correction: add 3 when digit >= 5
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - sequential double-dabble binary to packed BCD converter
// Optional leading-zero blank output enabled by BIN2BCD_LZB_EN.
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int  WIDTH  = 8,
  localparam int DIGITS = digits(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_LZB_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                state, state_next;
  logic [WIDTH-1:0]      bin_sr, bin_next;
  logic [4*DIGITS-1:0]   scratch, scratch_adj, scratch_next;
  logic [CW-1:0]         cnt;
  logic                  load, step, last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  // One double-dabble iteration: corrected scratch and binary shift together.
  assign {scratch_next, bin_next} = {scratch_adj, bin_sr} << 1;
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    valid      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_next;
  logic              upper_zero;

  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (scratch_next[4*i +: 4] == 4'd0);
      blank_next[i] = upper_zero;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             blank <= '0;
    else if (step && last) blank <= blank_next;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
    end else if (load) begin
      bin_sr  <= bin;
      scratch <= '0;
      cnt     <= '0;
    end else if (step) begin
      bin_sr  <= bin_next;
      scratch <= scratch_next;
      cnt     <= cnt + 1'b1;
      if (last) bcd <= scratch_next;
    end
  end

endmodule

// File: tb/tb_bin2bcd.sv
// tb/tb_bin2bcd.sv - directed scoreboard bench for bin2bcd (WIDTH=8)
module tb_bin2bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        valid;
  logic [11:0] bcd;
`ifdef BIN2BCD_LZB_EN
  logic [2:0]  blank;
`endif

  int compared    = 0;
  int mismatched  = 0;
  int valid_count = 0;
  logic [11:0] exp_q[$];

  bin2bcd #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .valid (valid),
    .bcd   (bcd)
`ifdef BIN2BCD_LZB_EN
    ,
    .blank (blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    if (rst && valid) begin
      valid_count++;
      if (exp_q.size() > 0) check("bcd", {20'd0, bcd}, {20'd0, exp_q.pop_front()});
      else                  check("spurious_valid", {31'd0, valid}, 32'd0);
    end
  end

  task automatic do_start(input logic [7:0] b);
    bin   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int busy_cycles, output bit got);
    busy_cycles = 0;
    got         = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic conv(input logic [7:0] b, input logic [11:0] e, input string tag);
    int bc;
    bit got;
    exp_q.push_back(e);
    do_start(b);
    wait_valid(bc, got);
    check({tag, "_valid"}, {31'd0, got}, 32'd1);
    check({tag, "_busy"}, bc, 32'd8);
    @(posedge clk); #1;
  endtask

  initial begin
    int bc;
    bit got;
    int vc;
    logic [7:0] rv;

    rst   = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_bcd", {20'd0, bcd}, 32'd0);
`ifdef BIN2BCD_LZB_EN
    check("rst_blank", {29'd0, blank}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;

    conv(8'd255, 12'h255, "b255");
    conv(8'd0,   12'h000, "b0");
    conv(8'd99,  12'h099, "b99");
    conv(8'd100, 12'h100, "b100");

    // second start while busy must be dropped
    exp_q.push_back(12'h255);
    vc = valid_count;
    do_start(8'd255);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_start(8'd7);
    wait_valid(bc, got);
    check("ign_valid", {31'd0, got}, 32'd1);
    repeat (15) @(posedge clk);
    #1;
    check("ign_single_pulse", valid_count - vc, 32'd1);

    // reset in the middle of a conversion
    vc = valid_count;
    do_start(8'd200);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_bcd", {20'd0, bcd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    conv(8'd42, 12'h042, "post_rst42");
    check("mid_rst_no_extra", valid_count - vc, 32'd1);

    // start during the valid cycle re-enters SHIFT directly
    exp_q.push_back(12'h100);
    do_start(8'd100);
    wait_valid(bc, got);
    check("rr_first_valid", {31'd0, got}, 32'd1);
    bin   = 8'd13;
    start = 1'b1;
    exp_q.push_back(12'h013);
    @(posedge clk); #1;
    start = 1'b0;
    check("rr_reentry_busy", {31'd0, busy}, 32'd1);
    wait_valid(bc, got);
    check("rr_second_valid", {31'd0, got}, 32'd1);
    check("rr_busy", bc, 32'd8);
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      rv = 8'($urandom_range(0, 255));
      conv(rv, to_bcd(int'(rv)), "rand");
    end

`ifdef BIN2BCD_LZB_EN
    conv(8'd7, 12'h007, "lz7");
    check("blank7", {29'd0, blank}, 32'b110);
    conv(8'd0, 12'h000, "lz0");
    check("blank0", {29'd0, blank}, 32'b110);
    conv(8'd150, 12'h150, "lz150");
    check("blank150", {29'd0, blank}, 32'b000);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
